// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS main control FSM.
// Moore outputs per state; pc_en also folds in the beq zero flag.
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t cur, nxt;

  logic       is_lw, is_sw, is_r, is_beq, is_addi, is_j;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       pc_write, branch;
  logic       mw_s, iw_s, rw_s;

  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_r    = (opcode == OP_R) && funct_ok;
  assign is_beq  = (opcode == OP_BEQ);
  assign is_addi = (opcode == OP_ADDI);
  assign is_j    = (opcode == OP_J);

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    unique case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    unique case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: nxt = S_MEMADR;
          is_r:         nxt = S_EXECUTE;
          is_beq:       nxt = S_BRANCH;
          is_addi:      nxt = S_ADDIEX;
          is_j:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = S_MEMWB;
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      default:   nxt = S_FETCH;
    endcase
  end

  always_comb begin
    iord          = 1'b0;
    mw_s          = 1'b0;
    iw_s          = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    rw_s          = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_control   = 3'b010;
    illegal_instr = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    unique case (cur)
      S_FETCH: begin
        alu_src_b = 2'b01;
        iw_s      = 1'b1;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b     = 2'b11;
        illegal_instr = ~(is_lw | is_sw | is_r |
                          is_beq | is_addi | is_j);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        rw_s       = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        mw_s = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        rw_s    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = 3'b110;
        pc_src      = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: rw_s = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      // Unused encodings drive everything low, ALU select included.
      default: alu_control = 3'b000;
    endcase
  end

  assign pc_en     = ~rst & (pc_write | (branch & zero_flag));
  assign mem_write = ~rst & mw_s;
  assign ir_write  = ~rst & iw_s;
  assign reg_write = ~rst & rw_s;
  assign state     = cur;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized bench for the multicycle MIPS controller.
// Reference: instruction-class state paths plus a per-state control table.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero_flag;
  logic       pc_en, iord, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, illegal_instr;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int n_run  = 0;
  int n_fail = 0;

  typedef int seq_t[$];

  always #5 clk = ~clk;

  mips_multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .pc_en(pc_en), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .illegal_instr(illegal_instr),
    .state(state)
  );

  // 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 j, 6 illegal
  function automatic int classify(input logic [5:0] op,
                                  input logic [5:0] fn);
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000100: return 3;
      6'b001000: return 4;
      6'b000010: return 5;
      6'b000000:
        if (fn inside {6'b100000, 6'b100010, 6'b100100,
                       6'b100101, 6'b101010}) return 2;
        else return 6;
      default: return 6;
    endcase
  endfunction

  function automatic seq_t path_of(input int c);
    case (c)
      0: return '{0, 1, 2, 3, 4};
      1: return '{0, 1, 2, 5};
      2: return '{0, 1, 6, 7};
      3: return '{0, 1, 8};
      4: return '{0, 1, 9, 10};
      5: return '{0, 1, 11};
      default: return '{0, 1};
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [15:0] model_out(
    input int st, input logic [5:0] op, input logic [5:0] fn,
    input logic z, input logic r);
    logic pe, io, mw, iw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pe, io, mw, iw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    case (st)
      0:  begin sb = 2'b01; iw = 1; pe = 1; end
      1:  begin sb = 2'b11; ill = (classify(op, fn) == 6); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; ac = alu_of(fn); end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ac = 3'b000;
    endcase
    if (r) begin pe = 0; mw = 0; rw = 0; iw = 0; end
    return {pe, io, mw, iw, m2r, rd, rw, sa, sb, ps, ac, ill};
  endfunction

  function automatic logic [15:0] obs();
    return {pc_en, iord, mem_write, ir_write, mem_to_reg, reg_dst,
            reg_write, alu_src_a, alu_src_b, pc_src, alu_control,
            illegal_instr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic z);
    opcode = op; funct = fn; zero_flag = z;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(6'b100011, 6'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      n_run++;
      if (state !== 4'd0)
        $display("FAIL reset_state got=%0d exp=0", state);
      if (state !== 4'd0) n_fail++;
      n_run++;
      if (obs() !== model_out(0, opcode, funct, 1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL reset_outs got=%b exp=%b", obs(),
                 model_out(0, opcode, funct, 1'b1, 1'b1));
      end
    end
    rst = 1'b0;
    #1;
    n_run++;
    if (obs() !== model_out(0, opcode, funct, 1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL post_reset_fetch got=%b exp=%b", obs(),
               model_out(0, opcode, funct, 1'b1, 1'b0));
    end
  endtask

  task automatic test_lw_sw();
    logic [5:0] ops [2] = '{6'b100011, 6'b101011};
    foreach (ops[i]) begin
      seq_t q;
      drive(ops[i], 6'($urandom), 1'($urandom));
      q = path_of(classify(opcode, funct));
      foreach (q[k]) begin
        n_run++;
        if (state !== 4'(q[k])) begin
          n_fail++;
          $display("FAIL mem_state got=%0d exp=%0d", state, q[k]);
        end
        n_run++;
        if (obs() !== model_out(q[k], opcode, funct, zero_flag, 0)) begin
          n_fail++;
          $display("FAIL mem_outs st=%0d got=%b exp=%b", q[k], obs(),
                   model_out(q[k], opcode, funct, zero_flag, 0));
        end
        step();
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100,
                            6'b100101, 6'b101010};
    foreach (fns[i]) begin
      seq_t q;
      drive(6'b000000, fns[i], 1'($urandom));
      q = path_of(classify(opcode, funct));
      n_run++;
      if (q.size() != 4) begin
        n_fail++;
        $display("FAIL rtype_cpi got=%0d exp=4", q.size());
      end
      foreach (q[k]) begin
        n_run++;
        if (state !== 4'(q[k]) ||
            obs() !== model_out(q[k], opcode, funct, zero_flag, 0)) begin
          n_fail++;
          $display("FAIL rtype st=%0d/%0d got=%b exp=%b", state, q[k],
                   obs(), model_out(q[k], opcode, funct, zero_flag, 0));
        end
        step();
      end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      seq_t q;
      drive(6'b000100, 6'($urandom), 1'(z));
      q = path_of(3);
      foreach (q[k]) begin
        n_run++;
        if (state !== 4'(q[k]) ||
            obs() !== model_out(q[k], opcode, funct, zero_flag, 0)) begin
          n_fail++;
          $display("FAIL beq z=%0d st=%0d/%0d got=%b exp=%b", z, state,
                   q[k], obs(), model_out(q[k], opcode, funct, 1'(z), 0));
        end
        step();
      end
    end
  endtask

  task automatic test_addi_j();
    logic [5:0] ops [2] = '{6'b001000, 6'b000010};
    foreach (ops[i]) begin
      seq_t q;
      drive(ops[i], 6'($urandom), 1'($urandom));
      q = path_of(classify(opcode, funct));
      foreach (q[k]) begin
        n_run++;
        if (state !== 4'(q[k]) ||
            obs() !== model_out(q[k], opcode, funct, zero_flag, 0)) begin
          n_fail++;
          $display("FAIL addi_j st=%0d/%0d got=%b exp=%b", state, q[k],
                   obs(), model_out(q[k], opcode, funct, zero_flag, 0));
        end
        step();
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'b111111, 6'b000000};
    foreach (ops[i]) begin
      seq_t q;
      drive(ops[i], 6'b000000, 1'($urandom));
      q = path_of(classify(opcode, funct));
      n_run++;
      if (q.size() != 2) begin
        n_fail++;
        $display("FAIL illegal_cpi got=%0d exp=2", q.size());
      end
      foreach (q[k]) begin
        n_run++;
        if (state !== 4'(q[k]) ||
            obs() !== model_out(q[k], opcode, funct, zero_flag, 0)) begin
          n_fail++;
          $display("FAIL illegal st=%0d/%0d got=%b exp=%b", state, q[k],
                   obs(), model_out(q[k], opcode, funct, zero_flag, 0));
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] ops [2] = '{6'b100011, 6'b101011};
    int         tgt [2] = '{3, 5};
    foreach (ops[i]) begin
      drive(ops[i], 6'b0, 1'b0);
      for (int k = 0; k < 3; k++) step();
      n_run++;
      if (state !== 4'(tgt[i])) begin
        n_fail++;
        $display("FAIL mid_pre st got=%0d exp=%0d", state, tgt[i]);
      end
      rst = 1'b1;
      #1;
      n_run++;
      if (obs() !== model_out(tgt[i], opcode, funct, 1'b0, 1'b1)) begin
        n_fail++;
        $display("FAIL mid_rst_outs got=%b exp=%b", obs(),
                 model_out(tgt[i], opcode, funct, 1'b0, 1'b1));
      end
      step();
      step();
      n_run++;
      if (state !== 4'd0 ||
          obs() !== model_out(0, opcode, funct, 1'b0, 1'b1)) begin
        n_fail++;
        $display("FAIL mid_rst_fetch st=%0d got=%b exp=%b", state, obs(),
                 model_out(0, opcode, funct, 1'b0, 1'b1));
      end
      rst = 1'b0;
      #1;
    end
  endtask

  task automatic test_random();
    logic [5:0] legal [6] = '{6'b100011, 6'b101011, 6'b000000,
                              6'b000100, 6'b001000, 6'b000010};
    for (int n = 0; n < 60; n++) begin
      seq_t q;
      int   pick = $urandom_range(0, 7);
      logic [5:0] op = (pick < 6) ? legal[pick] : 6'($urandom);
      drive(op, 6'($urandom), 1'($urandom));
      q = path_of(classify(opcode, funct));
      foreach (q[k]) begin
        n_run++;
        if (state !== 4'(q[k]) ||
            obs() !== model_out(q[k], opcode, funct, zero_flag, 0)) begin
          n_fail++;
          $display("FAIL rand op=%b fn=%b st=%0d/%0d got=%b exp=%b",
                   opcode, funct, state, q[k], obs(),
                   model_out(q[k], opcode, funct, zero_flag, 0));
        end
        step();
      end
    end
    n_run++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL final_fetch got=%0d exp=0", state);
    end
  endtask

  initial begin
    test_reset();
    test_lw_sw();
    test_rtype();
    test_beq();
    test_addi_j();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Main control unit for the multicycle MIPS datapath, sitting directly upstream of the ALU. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback for each instruction. It drives the ALU's 3-bit operation select and the datapath's mux and write-enable controls, and it consumes the ALU zero flag to resolve `beq`.

## Interface
Parameters:
- none (opcode, funct and ALU encodings are fixed by the ISA subset below)

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  instr[31:26], from the instruction register
- `funct`  in  6  instr[5:0], from the instruction register
- `zero_flag`  in  1  ALU zero flag
- `pc_en`  out  1  PC register load enable
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  data memory write enable
- `ir_write`  out  1  instruction register load enable
- `mem_to_reg`  out  1  register-file write data select: 0 = ALUOut, 1 = memory data
- `reg_dst`  out  1  destination register select: 0 = rt, 1 = rd
- `reg_write`  out  1  register-file write enable
- `alu_src_a`  out  1  ALU operand A select: 0 = PC, 1 = register A
- `alu_src_b`  out  2  ALU operand B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_control`  out  3  ALU operation select: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- `illegal_instr`  out  1  one-cycle pulse when an unsupported instruction is decoded
- `state`  out  4  current state encoding, for debug and verification

## Operation
- Supported opcodes:
  - lw = 100011
  - sw = 101011
  - R-type = 000000
  - beq = 000100
  - addi = 001000
  - j = 000010
- Supported R-type funct values and the `alu_control` they select:
  - add 100000 → 010
  - sub 100010 → 110
  - and 100100 → 000
  - or 100101 → 001
  - slt 101010 → 111
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 are unused.
- Outputs are a pure function of `state`, except `pc_en`. Any output not listed for a state is 0. `alu_control` is 010 in every state except EXECUTE and BRANCH.
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, ir_write=1, pc_write=1
  - DECODE: alu_src_a=0, alu_src_b=11
  - MEMADR: alu_src_a=1, alu_src_b=10
  - MEMRD: iord=1
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1
  - MEMWR: iord=1, mem_write=1
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_control=funct decode
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, branch=1
  - ADDIEX: alu_src_a=1, alu_src_b=10
  - ADDIWB: reg_dst=0, reg_write=1
  - JUMP: pc_src=10, pc_write=1
- `pc_en` = pc_write | (branch & zero_flag). It is the only output that depends combinationally on an input.
- State transitions:
  - FETCH → DECODE
  - DECODE → MEMADR for lw/sw; EXECUTE for R-type with a supported funct; BRANCH for beq; ADDIEX for addi; JUMP for j; otherwise FETCH
  - MEMADR → MEMRD for lw; MEMWR for sw
  - MEMRD → MEMWB
  - EXECUTE → ALUWB
  - ADDIEX → ADDIWB
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP → FETCH
- Illegal instructions (unsupported opcode, or R-type with an unsupported funct):
  - `illegal_instr`=1 during the DECODE cycle only.
  - No register or memory write occurs.
  - The PC has already advanced by 4 in FETCH.
- An unreachable state (12–15) → FETCH on the next edge, with all outputs at their default 0.
- `opcode` and `funct` are sampled only in DECODE, MEMADR and EXECUTE. The IR is loaded only in FETCH, so both are stable in those states.

## Timing
- Reset:
  - `rst` high at a rising edge → `state`=FETCH (0) after that edge.
  - While `rst` is high, `pc_en`, `mem_write`, `reg_write` and `ir_write` are forced to 0 regardless of state. Other outputs follow the current state.
  - Reset mid-instruction abandons the instruction. No partial write is issued in the reset cycle.
- First cycle after reset release is FETCH, with FETCH outputs (alu_control=010, alu_src_b=01, ir_write=1, pc_en=1).
- Cycles per instruction, FETCH to last state inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Branch resolution: in the BRANCH cycle, `zero_flag` is used in the same cycle. `pc_en` rises combinationally when zero_flag=1 and is 0 otherwise.
- No stalls and no handshake: memory is single-cycle.

## Test plan
- Reset: hold `rst` 2 cycles from an arbitrary state (e.g. MEMRD) → state=0. pc_en, mem_write, reg_write and ir_write are 0 while `rst` is high. The first post-reset cycle shows ir_write=1, pc_en=1, alu_src_b=01.
- lw (opcode 100011): states 0→1→2→3→4→0. MEMADR shows alu_src_b=10, alu_control=010. MEMRD shows iord=1. MEMWB shows mem_to_reg=1, reg_write=1, reg_dst=0. sw (opcode 101011): 0→1→2→5→0, with mem_write=1 only in state 5.
- R-type sweep, one instruction per funct: funct 100000/100010/100100/100101/101010 → `alu_control` in EXECUTE = 010/110/000/001/111, followed by ALUWB with reg_dst=1, reg_write=1.
- beq (opcode 000100): with zero_flag=1 in BRANCH → pc_en=1, pc_src=01, alu_control=110. With zero_flag=0 → pc_en=0. Both cases return to FETCH after 3 cycles.
- addi (opcode 001000) → states 0,1,9,10,0 with reg_dst=0 in ADDIWB. j (opcode 000010) → JUMP with pc_src=10, pc_en=1.
- Illegal: opcode 111111, and R-type with funct 000000 → illegal_instr=1 for exactly the DECODE cycle, then FETCH. No reg_write or mem_write pulse occurs.
